// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// result-source codes and the MUL/DIV sequencer state type.
package hazard_pkg;

    localparam logic [1:0] FWD_REG  = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] RES_LOAD = 2'b01;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_t;

    // A younger producer (MEM) shadows an older one (WB); x0 is hardwired zero.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        if (wr_m && rd_m != 5'd0 && rd_m == rs)
            return FWD_MEM;
        else if (wr_w && rd_w != 5'd0 && rd_w == rs)
            return FWD_WB;
        else
            return FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_seq.sv
// MUL/DIV sequencer: holds the pipeline while a multi-cycle op occupies EX and
// flags the cycle its result is valid.
module mdu_seq
    import hazard_pkg::*;
#(
    parameter int MDU_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic MduStartE,
    output logic mduStall,
    output logic MduDone
);

    // The first EX cycle is spent in IDLE, so BUSY counts down the remaining stalls.
    localparam logic [3:0] CNT_LOAD = (MDU_LAT > 1) ? 4'(MDU_LAT - 2) : 4'd0;

    mdu_state_t state, state_n;
    logic [3:0] cnt, cnt_n;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        mduStall = 1'b0;
        MduDone  = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (MduStartE) begin
                        if (MDU_LAT > 1) begin
                            mduStall = 1'b1;
                            cnt_n    = CNT_LOAD;
                            state_n  = BUSY;
                        end else begin
                            MduDone = 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        mduStall = 1'b1;
                        cnt_n    = cnt - 4'd1;
                    end else begin
                        MduDone = 1'b1;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: EX forwarding selects, stall/flush
// priority (MUL/DIV hold > branch flush > load-use) and saturating perf counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       rdE,
    input  logic [4:0]       rdM,
    input  logic [4:0]       rdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic             MduStartE,
    input  logic             perf_clr,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             MduDone,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
);

    logic mdu_stall;
    logic lw_stall;

    mdu_seq #(.MDU_LAT(MDU_LAT)) u_mdu_seq (
        .clk       (clk),
        .rst       (rst),
        .MduStartE (MduStartE),
        .mduStall  (mdu_stall),
        .MduDone   (MduDone)
    );

    assign ForwardAE = fwd_sel(Rs1E, rdM, RegWriteM, rdW, RegWriteW);
    assign ForwardBE = fwd_sel(Rs2E, rdM, RegWriteM, rdW, RegWriteW);

    assign lw_stall = (ResultSrcE == RES_LOAD) && (rdE != 5'd0) &&
                      ((rdE == Rs1D) || (rdE == Rs2D));

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (rst) begin
            // everything stays deasserted
        end else if (mdu_stall) begin
            // The held MUL/DIV must never be flushed, so the branch waits behind it.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (StallF && stall_cycles != '1)
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (FlushE && flush_cycles != '1)
                flush_cycles <= flush_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: three builds (default, single-cycle MDU,
// 4-bit counters) share stimulus and are compared against an age-based model.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, rdE, rdM, rdW;
    logic       RegWriteM, RegWriteW, PCSrcE, MduStartE, perf_clr;
    logic [1:0] ResultSrcE;

    logic [1:0]  fa_a, fb_a, fa_b, fb_b, fa_c, fb_c;
    logic        sf_a, sd_a, se_a, fd_a, fe_a, dn_a;
    logic        sf_b, sd_b, se_b, fd_b, fe_b, dn_b;
    logic        sf_c, sd_c, se_c, fd_c, fe_c, dn_c;
    logic [31:0] sc_a, fc_a, sc_b, fc_b;
    logic [3:0]  sc_c, fc_c;

    int errors = 0;
    int checks = 0;

    hazard_ctrl #(.MDU_LAT(4), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .rdE(rdE), .rdM(rdM), .rdW(rdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MduStartE(MduStartE), .perf_clr(perf_clr),
        .ForwardAE(fa_a), .ForwardBE(fb_a), .StallF(sf_a), .StallD(sd_a), .StallE(se_a),
        .FlushD(fd_a), .FlushE(fe_a), .MduDone(dn_a), .stall_cycles(sc_a), .flush_cycles(fc_a)
    );

    hazard_ctrl #(.MDU_LAT(1), .CNT_W(32)) dut_b (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .rdE(rdE), .rdM(rdM), .rdW(rdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MduStartE(MduStartE), .perf_clr(perf_clr),
        .ForwardAE(fa_b), .ForwardBE(fb_b), .StallF(sf_b), .StallD(sd_b), .StallE(se_b),
        .FlushD(fd_b), .FlushE(fe_b), .MduDone(dn_b), .stall_cycles(sc_b), .flush_cycles(fc_b)
    );

    hazard_ctrl #(.MDU_LAT(4), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .rdE(rdE), .rdM(rdM), .rdW(rdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MduStartE(MduStartE), .perf_clr(perf_clr),
        .ForwardAE(fa_c), .ForwardBE(fb_c), .StallF(sf_c), .StallD(sd_c), .StallE(se_c),
        .FlushD(fd_c), .FlushE(fe_c), .MduDone(dn_c), .stall_cycles(sc_c), .flush_cycles(fc_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: each build tracks how many cycles its current MUL/DIV has spent in EX.
    int     lat   [3] = '{4, 1, 4};
    longint cmax  [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hF};
    bit     m_busy[3];
    int     m_age [3];
    longint m_sc  [3];
    longint m_fc  [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] outs(input int i);
        case (i)
            0:       return {fa_a, fb_a, sf_a, sd_a, se_a, fd_a, fe_a, dn_a};
            1:       return {fa_b, fb_b, sf_b, sd_b, se_b, fd_b, fe_b, dn_b};
            default: return {fa_c, fb_c, sf_c, sd_c, se_c, fd_c, fe_c, dn_c};
        endcase
    endfunction

    function automatic logic [31:0] scnt(input int i);
        case (i)
            0:       return sc_a;
            1:       return sc_b;
            default: return {28'd0, sc_c};
        endcase
    endfunction

    function automatic logic [31:0] fcnt(input int i);
        case (i)
            0:       return fc_a;
            1:       return fc_b;
            default: return {28'd0, fc_c};
        endcase
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (RegWriteM && rdM != 0 && rdM == rs) return 2'b10;
        if (RegWriteW && rdW != 0 && rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // One clock: check combinational outputs against the model, clock, then advance and check counters.
    task automatic step();
        logic [9:0] e;
        bit act, mst, mdn, lw, sf, sd, se, fd, fe;
        bit st_q[3], dn_q[3], sf_q[3], fe_q[3];
        int a;
        #1;
        lw = (ResultSrcE == 2'b01) && rdE != 0 && (rdE == Rs1D || rdE == Rs2D);
        for (int i = 0; i < 3; i++) begin
            a   = m_busy[i] ? m_age[i] : 0;
            act = !rst && (m_busy[i] || MduStartE);
            mst = act && (a < lat[i] - 1);
            mdn = act && (a == lat[i] - 1);
            {sf, sd, se, fd, fe} = '0;
            if (rst)          ;
            else if (mst)     {sf, sd, se} = 3'b111;
            else if (PCSrcE)  {fd, fe} = 2'b11;
            else if (lw)      {sf, sd, fe} = 3'b111;
            e = {m_fwd(Rs1E), m_fwd(Rs2E), sf, sd, se, fd, fe, mdn};
            check($sformatf("outs%0d", i), 32'(outs(i)), 32'(e));
            st_q[i] = mst; dn_q[i] = mdn; sf_q[i] = sf; fe_q[i] = fe;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (rst || dn_q[i]) m_busy[i] = 1'b0;
            else if (st_q[i]) begin
                m_age[i]  = m_busy[i] ? m_age[i] + 1 : 1;
                m_busy[i] = 1'b1;
            end
            if (rst || perf_clr) begin
                m_sc[i] = 0;
                m_fc[i] = 0;
            end else begin
                if (sf_q[i] && m_sc[i] < cmax[i]) m_sc[i]++;
                if (fe_q[i] && m_fc[i] < cmax[i]) m_fc[i]++;
            end
            check($sformatf("stall_cnt%0d", i), scnt(i), 32'(m_sc[i]));
            check($sformatf("flush_cnt%0d", i), fcnt(i), 32'(m_fc[i]));
        end
    endtask

    task automatic idle_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, rdE, rdM, rdW} = '0;
        {RegWriteM, RegWriteW, PCSrcE, MduStartE, perf_clr} = '0;
        ResultSrcE = 2'b00;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_busy[i] = 1'b0; m_age[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
        end
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Forwarding: MEM beats WB, WB alone, x0 never forwards
        rdM = 5'd5; RegWriteM = 1'b1; rdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5;
        step();
        check("fwdA_mem", 32'(fa_a), 32'd2);
        RegWriteM = 1'b0;
        step();
        check("fwdA_wb", 32'(fa_a), 32'd1);
        rdM = 5'd0; rdW = 5'd0; Rs1E = 5'd0; RegWriteM = 1'b1;
        step();
        check("fwdA_x0", 32'(fa_a), 32'd0);

        // Load-use bubble for exactly one cycle
        idle_inputs();
        ResultSrcE = 2'b01; rdE = 5'd7; Rs2D = 5'd7;
        step();
        ResultSrcE = 2'b00;
        step();
        check("lw_stall_cnt", sc_a, 32'd1);
        check("lw_flush_cnt", fc_a, 32'd1);

        // Branch flush overrides load-use
        ResultSrcE = 2'b01; PCSrcE = 1'b1;
        step();
        PCSrcE = 1'b0; ResultSrcE = 2'b00;
        step();

        // MUL/DIV held four cycles with a concurrent load-use
        ResultSrcE = 2'b01; MduStartE = 1'b1;
        for (int k = 0; k < 4; k++) step();
        MduStartE = 1'b0; ResultSrcE = 2'b00;
        step();

        // Reset in the middle of an MUL/DIV abandons it
        MduStartE = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; MduStartE = 1'b0;
        step();
        step();

        // Saturate the 4-bit stall counter, then clear it under a stall
        ResultSrcE = 2'b01;
        for (int k = 0; k < 20; k++) step();
        check("sat_c", 32'(sc_c), 32'hF);
        perf_clr = 1'b1;
        step();
        check("clr_c", 32'(sc_c), 32'h0);
        perf_clr = 1'b0;

        // Random traffic over a small register range to provoke matches
        for (int k = 0; k < 400; k++) begin
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            rdE  = 5'($urandom_range(0, 3)); rdM  = 5'($urandom_range(0, 3));
            rdW  = 5'($urandom_range(0, 3));
            RegWriteM  = 1'($urandom_range(0, 1));
            RegWriteW  = 1'($urandom_range(0, 1));
            ResultSrcE = 2'($urandom_range(0, 3));
            PCSrcE     = ($urandom_range(0, 3) == 0);
            MduStartE  = ($urandom_range(0, 2) == 0);
            perf_clr   = ($urandom_range(0, 31) == 0);
            rst        = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and sequencing controller for the 5-stage RV32 core. It owns stall and flush control of the IF/ID and ID/EX registers, and generates the EX-stage forwarding selects. It sequences multi-cycle MUL/DIV ops in EX by holding the pipeline for a fixed latency. It also keeps saturating performance counters for stall and flush cycles.

Parameters:
MDU_LAT, 4, total EX-stage cycles of a MUL/DIV op (1..16); 1 means single-cycle, no stall.
CNT_W, 32, width of performance counters.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
Rs1D  in  5  rs1 of instruction in ID
Rs2D  in  5  rs2 of instruction in ID
Rs1E  in  5  rs1 of instruction in EX
Rs2E  in  5  rs2 of instruction in EX
rdE  in  5  rd in EX
rdM  in  5  rd in MEM
rdW  in  5  rd in WB
RegWriteM  in  1  MEM instruction writes rd
RegWriteW  in  1  WB instruction writes rd
ResultSrcE  in  2  EX result source; 2'b01 = load
PCSrcE  in  1  taken branch/jump resolved in EX
MduStartE  in  1  EX holds a MUL/DIV op (level, stays high while held)
perf_clr  in  1  synchronous clear of perf counters
ForwardAE  out  2  operand A select: 00 reg, 01 WB, 10 MEM
ForwardBE  out  2  operand B select, same encoding
StallF  out  1  hold PC
StallD  out  1  hold IF/ID
StallE  out  1  hold ID/EX
FlushD  out  1  clear IF/ID
FlushE  out  1  clear ID/EX
MduDone  out  1  MUL/DIV result valid this cycle
stall_cycles  out  CNT_W  count of cycles with StallF=1
flush_cycles  out  CNT_W  count of cycles with FlushE=1

Behaviour:
- Forwarding is combinational, per operand (Rs1E→A, Rs2E→B):
  - MEM match wins: RegWriteM && rdM!=0 && rdM==RsXE → 10.
  - Else WB match: RegWriteW && rdW!=0 && rdW==RsXE → 01.
  - Else 00.
  - x0 never forwards.
- Load-use: lwStall = (ResultSrcE==2'b01) && rdE!=0 && (rdE==Rs1D || rdE==Rs2D).
- MDU sequencer FSM, states IDLE and BUSY, 4-bit counter cnt:
  - IDLE, MduStartE=1, MDU_LAT>1: mduStall=1, cnt<=MDU_LAT-2, go BUSY.
  - IDLE, MduStartE=1, MDU_LAT=1: MduDone=1 same cycle, stay IDLE.
  - BUSY, cnt!=0: mduStall=1, cnt<=cnt-1.
  - BUSY, cnt==0: MduDone=1, mduStall=0, go IDLE.
  - MduStartE is ignored in BUSY (it is the same held op).
  - Result: op entering EX at cycle t stalls cycles t..t+MDU_LAT-2 and has MduDone at t+MDU_LAT-1.
- Output priority, highest first:
  1. rst=1: all stall/flush outputs 0, MduDone=0.
  2. mduStall: StallF=StallD=StallE=1, FlushD=FlushE=0. The held EX op is never flushed; lwStall and PCSrcE are masked.
  3. PCSrcE: FlushD=FlushE=1, StallF=StallD=0. Flush overrides a simultaneous lwStall.
  4. lwStall: StallF=StallD=1, FlushE=1 (bubble), StallE=0.
  5. Otherwise all 0.
- Perf counters:
  - Increment by 1 on cycles where the named output is 1.
  - Saturate at all-ones.
  - perf_clr zeroes both; perf_clr takes precedence over increment in the same cycle.
- Reset:
  - State←IDLE, cnt←0, counters←0, all registered state cleared at the rst edge.
  - Reset mid-MDU abandons the op; no MduDone is issued.
  - Outputs after reset: ForwardAE/BE combinational from inputs, all others 0.

Decomposition:
- Package hazard_pkg holds:
  - FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - RES_LOAD=2'b01.
  - MDU FSM state enum (IDLE, BUSY).
- Sub-module mdu_seq holds the FSM and counter.
  - Inputs: clk, rst, MduStartE.
  - Outputs: mduStall, MduDone.
- Forwarding, priority logic and perf counters stay in hazard_ctrl.

Test Plan:
1. Forwarding: rdM=5, RegWriteM=1, rdW=5, RegWriteW=1, Rs1E=5 → ForwardAE=10. Drop RegWriteM → 01. Repeat with rdM=rdW=0, Rs1E=0 → 00.
2. Load-use: ResultSrcE=01, rdE=7, Rs2D=7 → StallF=StallD=FlushE=1, StallE=0 for exactly 1 cycle; stall_cycles=1, flush_cycles=1.
3. Branch+load-use: same as 2 plus PCSrcE=1 → FlushD=FlushE=1, StallF=StallD=0.
4. MDU, MDU_LAT=4: MduStartE held high from cycle t → StallF/D/E=1 on t, t+1, t+2; MduDone=1 on t+3 only; FlushE=0 throughout, even with concurrent lwStall. Rerun with MDU_LAT=1 → no stall, MduDone at t.
5. Reset mid-MDU: assert rst at t+1 → cycle t+1 outputs 0; at t+2, with MduStartE=0, FSM is IDLE, no MduDone.
6. Counters: preload stall_cycles to all-ones via forced stalls (CNT_W=4 build) → holds 4'hF; perf_clr with a concurrent stall → 0.
